// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - two-master arbiter sharing the mips_cpu_bus memory port
//
// Purpose:
//   Shares one memory bus between the data port (m0) and the instruction-fetch
//   port (m1). Only one transaction is in flight at a time. Slave waitrequest is
//   honoured, and read data is returned to the owning master with a one-cycle
//   valid strobe.
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   m0_* / m1_*         master ports: address, read, write, writedata, byteenable
//                       (in); waitrequest, readdata, readdatavalid (out)
//   address, read, write, writedata, byteenable
//                       slave request outputs
//   waitrequest         slave stall input
//   readdata            slave read data, valid the cycle after acceptance
//
// Parameter:
//   ROUND_ROBIN         1 = alternate on ties, 0 = m0 always wins ties

module mips_bus_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,

  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GRANT0 = 3'd1,
    GRANT1 = 3'd2,
    RDATA0 = 3'd3,
    RDATA1 = 3'd4
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_grant;
  logic   last_grant_next;

  logic   req0;
  logic   req1;
  logic   pick1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On a tie, round-robin hands the bus to whichever master did not own the
  // last accepted transaction; fixed priority always favours the data port.
  always_comb begin
    if (req0 && req1) begin
      pick1 = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end else begin
      pick1 = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next       = state;
    last_grant_next  = last_grant;

    address          = 32'd0;
    read             = 1'b0;
    write            = 1'b0;
    writedata        = 32'd0;
    byteenable       = 4'd0;

    m0_waitrequest   = 1'b1;
    m0_readdata      = 32'd0;
    m0_readdatavalid = 1'b0;
    m1_waitrequest   = 1'b1;
    m1_readdata      = 32'd0;
    m1_readdatavalid = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = pick1 ? GRANT1 : GRANT0;
        end
      end

      GRANT0: begin
        address        = m0_address;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        // A simultaneous read and write is forwarded as a write only.
        write          = m0_write;
        read           = m0_read & ~m0_write;
        m0_waitrequest = waitrequest;
        if (!req0) begin
          // Master withdrew its request: abandon without touching last_grant.
          state_next = IDLE;
        end else if (!waitrequest) begin
          last_grant_next = 1'b0;
          state_next      = m0_write ? IDLE : RDATA0;
        end
      end

      GRANT1: begin
        address        = m1_address;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        write          = m1_write;
        read           = m1_read & ~m1_write;
        m1_waitrequest = waitrequest;
        if (!req1) begin
          state_next = IDLE;
        end else if (!waitrequest) begin
          last_grant_next = 1'b1;
          state_next      = m1_write ? IDLE : RDATA1;
        end
      end

      RDATA0: begin
        m0_readdatavalid = 1'b1;
        m0_readdata      = readdata;
        state_next       = IDLE;
      end

      RDATA1: begin
        m1_readdatavalid = 1'b1;
        m1_readdata      = readdata;
        state_next       = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // While reset is asserted the bus is quiesced immediately, so an in-flight
    // read loses its valid strobe in the very cycle reset arrives and a
    // pending grant cannot be accepted by the slave.
    if (reset) begin
      address          = 32'd0;
      read             = 1'b0;
      write            = 1'b0;
      writedata        = 32'd0;
      byteenable       = 4'd0;
      m0_waitrequest   = 1'b1;
      m0_readdata      = 32'd0;
      m0_readdatavalid = 1'b0;
      m1_waitrequest   = 1'b1;
      m1_readdata      = 32'd0;
      m1_readdatavalid = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - self-checking bench for mips_bus_arbiter

module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
  logic [3:0]  m1_byteenable;

  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_address, fp_writedata, fp_readdata;
  logic        fp_m0_waitrequest, fp_m0_readdatavalid, fp_m1_waitrequest, fp_m1_readdatavalid;
  logic        fp_read, fp_write;
  logic [3:0]  fp_byteenable;

  mips_bus_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_bus_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata),
    .m0_readdatavalid(fp_m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata),
    .m1_readdatavalid(fp_m1_readdatavalid),
    .address(fp_address), .read(fp_read), .write(fp_write), .writedata(fp_writedata),
    .byteenable(fp_byteenable), .waitrequest(waitrequest), .readdata(fp_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails = 0;

  typedef struct packed {
    logic        master;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h3C08_BFC0;
    return 32'h5A00_0000 | (32'(i) << 8) | 32'(i);
  endfunction

  function automatic logic [31:0] addr_of(input int i);
    return 32'hBFC0_0000 + 32'(i * 4);
  endfunction

  // Memory slave: registered read data, byte-lane writes.
  logic [31:0] mem [0:63];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (write && !waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (byteenable[b]) mem[address[7:2]][8*b +: 8] <= writedata[8*b +: 8];
    end
    if (read && !waitrequest) readdata <= mem[address[7:2]];
    if (fp_read && !waitrequest) fp_readdata <= mem[fp_address[7:2]];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters;
    m0_address = 32'd0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'd0; m0_byteenable = 4'hF;
    m1_address = 32'd0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'd0; m1_byteenable = 4'hF;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    waitrequest = 1'b0;
    idle_masters();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    waitrequest = 1'b0;
    idle_masters();
    m0_read = 1'b1; m0_address = addr_of(1);
    m1_read = 1'b1; m1_address = addr_of(2);
    tick();
    @(negedge clk);
    vectors++;
    if ({read, write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
      fails++;
      $display("FAIL reset_strobes: got %b expected 001100",
               {read, write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
    end
    vectors++;
    if (address !== 32'd0) begin
      fails++; $display("FAIL reset_address: got %h expected 00000000", address);
    end
    tick();
    reset = 1'b0;
    idle_masters();
    @(negedge clk);
    vectors++;
    if ({read, write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid} !== 6'b001100) begin
      fails++;
      $display("FAIL reset_idle: got %b expected 001100",
               {read, write, m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid});
    end
    tick();
  endtask

  task automatic test_m1_read;
    exp_t e;
    do_reset();
    m1_read = 1'b1; m1_address = 32'hBFC0_0000;
    sb.push_back({1'b1, 32'h3C08_BFC0});
    @(negedge clk);
    vectors++;
    if ({read, m1_waitrequest} !== 2'b01) begin
      fails++; $display("FAIL m1rd_idle: got %b expected 01", {read, m1_waitrequest});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({read, write, m0_waitrequest, m1_waitrequest} !== 4'b1010) begin
      fails++; $display("FAIL m1rd_grant: got %b expected 1010", {read, write, m0_waitrequest, m1_waitrequest});
    end
    vectors++;
    if (address !== 32'hBFC0_0000) begin
      fails++; $display("FAIL m1rd_addr: got %h expected bfc00000", address);
    end
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01) begin
      fails++; $display("FAIL m1rd_valid: got %b expected 01", {m0_readdatavalid, m1_readdatavalid});
    end
    vectors++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL m1rd_sb: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      if (m1_readdata !== e.data) begin
        fails++; $display("FAIL m1rd_data: got %h expected %h", m1_readdata, e.data);
      end
    end
    vectors++;
    if (m0_readdata !== 32'd0) begin
      fails++; $display("FAIL m1rd_m0data: got %h expected 00000000", m0_readdata);
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      fails++; $display("FAIL m1rd_after: got %b expected 00", {m0_readdatavalid, m1_readdatavalid});
    end
    tick();
  endtask

  task automatic test_round_robin;
    exp_t e;
    logic [31:0] data;
    int got;
    int last;
    do_reset();
    m0_read = 1'b1; m0_address = addr_of(2);
    m1_read = 1'b1; m1_address = addr_of(3);
    repeat (2) begin
      sb.push_back({1'b0, init_word(2)});
      sb.push_back({1'b1, init_word(3)});
    end
    got = 0;
    last = 0;
    for (int n = 0; n < 30 && got < 4; n++) begin
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        vectors++;
        if (m0_readdatavalid && m1_readdatavalid) begin
          fails++; $display("FAIL rr_both_valid: got 11 expected one-hot");
        end
        vectors++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL rr_sb: got empty queue expected entry");
        end else begin
          e = sb.pop_front();
          data = m1_readdatavalid ? m1_readdata : m0_readdata;
          if (m1_readdatavalid !== e.master || data !== e.data) begin
            fails++;
            $display("FAIL rr_order: got m%0b %h expected m%0b %h", m1_readdatavalid, data, e.master, e.data);
          end
        end
        if (got > 0) begin
          vectors++;
          if (cyc - last != 3) begin
            fails++; $display("FAIL rr_gap: got %0d expected 3", cyc - last);
          end
        end
        last = cyc;
        got++;
      end
      tick();
    end
    idle_masters();
    vectors++;
    if (got != 4) begin
      fails++; $display("FAIL rr_timeout: got %0d strobes expected 4", got);
    end
    sb.delete();
    tick();
  endtask

  task automatic test_fixed_priority;
    exp_t e;
    int got;
    do_reset();
    m0_read = 1'b1; m0_address = addr_of(4);
    m1_read = 1'b1; m1_address = addr_of(5);
    repeat (3) sb.push_back({1'b0, init_word(4)});
    got = 0;
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      vectors++;
      if ({fp_m1_waitrequest, fp_m1_readdatavalid, fp_write} !== 3'b100 ||
          (fp_read && fp_address !== addr_of(4))) begin
        fails++;
        $display("FAIL fp_starve: got wr=%b v=%b rd=%b addr=%h expected m1 held off",
                 fp_m1_waitrequest, fp_m1_readdatavalid, fp_read, fp_address);
      end
      if (fp_m0_readdatavalid) begin
        vectors++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL fp_sb: got empty queue expected entry");
        end else begin
          e = sb.pop_front();
          if (fp_m0_readdata !== e.data) begin
            fails++; $display("FAIL fp_m0_data: got %h expected %h", fp_m0_readdata, e.data);
          end
        end
        got++;
      end
      tick();
    end
    vectors++;
    if (got != 3) begin
      fails++; $display("FAIL fp_m0_count: got %0d expected 3", got);
    end
    sb.delete();
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fp_read, fp_m1_waitrequest} !== 2'b01) begin
      fails++; $display("FAIL fp_idle: got %b expected 01", {fp_read, fp_m1_waitrequest});
    end
    tick();
    sb.push_back({1'b1, init_word(5)});
    @(negedge clk);
    vectors++;
    if ({fp_read, fp_write, fp_m1_waitrequest, fp_m0_waitrequest} !== 4'b1001 || fp_address !== addr_of(5)) begin
      fails++;
      $display("FAIL fp_m1_grant: got %b %h expected 1001 %h",
               {fp_read, fp_write, fp_m1_waitrequest, fp_m0_waitrequest}, fp_address, addr_of(5));
    end
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL fp_sb1: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (fp_m1_readdatavalid !== 1'b1 || fp_m1_readdata !== e.data) begin
        fails++;
        $display("FAIL fp_m1_data: got v=%b %h expected v=1 %h", fp_m1_readdatavalid, fp_m1_readdata, e.data);
      end
    end
    tick();
  endtask

  task automatic test_stall;
    exp_t e;
    do_reset();
    waitrequest = 1'b1;
    m0_read = 1'b1; m0_address = addr_of(6);
    sb.push_back({1'b0, init_word(6)});
    @(negedge clk);
    vectors++;
    if ({read, m0_waitrequest} !== 2'b01) begin
      fails++; $display("FAIL stall_idle: got %b expected 01", {read, m0_waitrequest});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      vectors++;
      if ({read, m0_waitrequest, m0_readdatavalid} !== 3'b110 || address !== addr_of(6)) begin
        fails++;
        $display("FAIL stall_hold%0d: got %b %h expected 110 %h",
                 k, {read, m0_waitrequest, m0_readdatavalid}, address, addr_of(6));
      end
    end
    tick();
    waitrequest = 1'b0;
    @(negedge clk);
    vectors++;
    if ({read, m0_waitrequest} !== 2'b10 || address !== addr_of(6)) begin
      fails++; $display("FAIL stall_accept: got %b %h expected 10 %h", {read, m0_waitrequest}, address, addr_of(6));
    end
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL stall_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== e.data) begin
        fails++; $display("FAIL stall_data: got v=%b %h expected v=1 %h", m0_readdatavalid, m0_readdata, e.data);
      end
    end
    tick();
  endtask

  task automatic test_write;
    exp_t e;
    logic [31:0] old_word;
    logic [31:0] new_word;
    do_reset();
    old_word = init_word(11);
    new_word = {old_word[31:16], 16'hABCD};
    m0_write = 1'b1; m0_read = 1'b1;
    m0_address = 32'hBFC0_002C; m0_writedata = 32'h0000_ABCD; m0_byteenable = 4'b0011;
    @(negedge clk);
    vectors++;
    if ({read, write} !== 2'b00) begin
      fails++; $display("FAIL wr_idle: got %b expected 00", {read, write});
    end
    tick();
    @(negedge clk);
    vectors++;
    if ({read, write, m0_waitrequest} !== 3'b010) begin
      fails++; $display("FAIL wr_strobe: got %b expected 010", {read, write, m0_waitrequest});
    end
    vectors++;
    if ({address, writedata, byteenable} !== {32'hBFC0_002C, 32'h0000_ABCD, 4'b0011}) begin
      fails++; $display("FAIL wr_bus: got %h %h %b expected bfc0002c 0000abcd 0011", address, writedata, byteenable);
    end
    tick();
    m0_write = 1'b0; m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({read, write, m0_readdatavalid, m1_readdatavalid, m0_waitrequest} !== 5'b00001) begin
      fails++;
      $display("FAIL wr_done: got %b expected 00001", {read, write, m0_readdatavalid, m1_readdatavalid, m0_waitrequest});
    end
    tick();
    m0_read = 1'b1; m0_byteenable = 4'hF;
    sb.push_back({1'b0, new_word});
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL wr_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if (m0_readdatavalid !== 1'b1 || m0_readdata !== e.data) begin
        fails++; $display("FAIL wr_readback: got v=%b %h expected v=1 %h", m0_readdatavalid, m0_readdata, e.data);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_rdata;
    exp_t e;
    do_reset();
    m0_read = 1'b1; m0_address = addr_of(7);
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    reset = 1'b1;
    m0_read = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid, read, write, m0_waitrequest, m1_waitrequest} !== 6'b000011) begin
      fails++;
      $display("FAIL rstmid_cycle: got %b expected 000011",
               {m0_readdatavalid, m1_readdatavalid, read, write, m0_waitrequest, m1_waitrequest});
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({m0_readdatavalid, m1_readdatavalid, read, write, m0_waitrequest, m1_waitrequest} !== 6'b000011) begin
      fails++;
      $display("FAIL rstmid_after: got %b expected 000011",
               {m0_readdatavalid, m1_readdatavalid, read, write, m0_waitrequest, m1_waitrequest});
    end
    tick();
    m1_read = 1'b1; m1_address = addr_of(8);
    sb.push_back({1'b1, init_word(8)});
    @(negedge clk);
    tick();
    @(negedge clk);
    vectors++;
    if ({read, m1_waitrequest} !== 2'b10 || address !== addr_of(8)) begin
      fails++; $display("FAIL rstmid_m1grant: got %b %h expected 10 %h", {read, m1_waitrequest}, address, addr_of(8));
    end
    tick();
    m1_read = 1'b0;
    @(negedge clk);
    vectors++;
    if (sb.size() == 0) begin
      fails++; $display("FAIL rstmid_sb: got empty queue expected entry");
    end else begin
      e = sb.pop_front();
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== e.data) begin
        fails++;
        $display("FAIL rstmid_m1data: got %b %h expected 01 %h", {m0_readdatavalid, m1_readdatavalid}, m1_readdata, e.data);
      end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    waitrequest = 1'b0;
    idle_masters();
    test_reset();
    test_m1_read();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_write();
    test_reset_mid_rdata();
    vectors++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL sb_drain: got %0d leftover expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
